// File: rtl/ita_softmax_denominator.sv
// Per-row streaming softmax denominator: rescales each row's running base-2 exponent
// sum by the max-difference and adds one tile per accept; emits (row, max, sum) on the last tile.
module ita_softmax_denominator #(
    parameter int N         = 16,
    parameter int WI        = 8,
    parameter int ROWS      = 64,
    parameter int EXP_SHIFT = 5,
    parameter int SUM_FRAC  = 8,
    parameter int SUM_W     = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [$clog2(ROWS)-1:0] row_i,
    input  logic                    last_tile_i,
    input  logic [N*WI-1:0]         x_i,
    output logic [WI-1:0]           prev_max_o,
    input  logic [WI-1:0]           max_i,
    input  logic [WI-1:0]           max_diff_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [$clog2(ROWS)-1:0] out_row_o,
    output logic [WI-1:0]           out_max_o,
    output logic [SUM_W-1:0]        out_sum_o
);

    localparam int DW  = WI + 1;                     // max_i - x_k never exceeds 2^WI - 1
    localparam int TW  = SUM_FRAC + 1;               // one exponent term, max 2^SUM_FRAC
    localparam int TSW = TW + $clog2(N);             // sum of N terms
    localparam int AW  = ((SUM_W > TSW) ? SUM_W : TSW) + 1;

    logic [WI-1:0]    max_mem [ROWS];
    logic [SUM_W-1:0] sum_mem [ROWS];
    logic [ROWS-1:0]  vld_q;

    logic             row_vld;
    logic [SUM_W-1:0] old_sum;
    logic [TSW-1:0]   tile_sum;
    logic [WI-1:0]    r_shift;
    logic [SUM_W-1:0] rescaled;
    logic [AW-1:0]    sum_ext;
    logic [SUM_W-1:0] new_sum;
    logic             accept;

    function automatic logic [TW-1:0] exp_term(input logic [WI-1:0] m, input logic [WI-1:0] x);
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        d = {m[WI-1], m} - {x[WI-1], x};
        e = d >> EXP_SHIFT;
        if (int'(e) > SUM_FRAC) return '0;
        return (TW'(1) << SUM_FRAC) >> e;
    endfunction

    assign row_vld    = vld_q[row_i];
    assign old_sum    = row_vld ? sum_mem[row_i] : '0;
    assign prev_max_o = row_vld ? max_mem[row_i] : {1'b1, {(WI-1){1'b0}}};

    // A full output register only blocks tiles that would need to load it.
    assign ready_o = !clear_i && !(last_tile_i && out_valid_o && !out_ready_i);
    assign accept  = valid_i && ready_o;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        tile_sum = '0;
        for (int k = 0; k < N; k++) begin
            tile_sum = tile_sum + TSW'(exp_term(max_i, x_i[k*WI +: WI]));
        end
    end

    always_comb begin
        r_shift  = max_diff_i >> EXP_SHIFT;
        rescaled = '0;
        if (int'(r_shift) < SUM_W) rescaled = old_sum >> r_shift;
        sum_ext  = AW'(rescaled) + AW'(tile_sum);
        new_sum  = (sum_ext > AW'({SUM_W{1'b1}})) ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else if (clear_i) begin
            vld_q <= '0;
        end else if (accept) begin
            vld_q[row_i] <= !last_tile_i;
        end
    end

    // NOTE: row storage has no reset; vld_q alone decides whether its contents mean anything.
    always_ff @(posedge clk_i) begin
        if (accept && !last_tile_i) begin
            max_mem[row_i] <= max_i;
            sum_mem[row_i] <= new_sum;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_row_o   <= '0;
            out_max_o   <= '0;
            out_sum_o   <= '0;
        end else if (accept && last_tile_i) begin
            out_valid_o <= 1'b1;
            out_row_o   <= row_i;
            out_max_o   <= max_i;
            out_sum_o   <= new_sum;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule
